spi_flash_rd_seq: RTL and testbench
===================================

# spi_flash_rd_seq

Read-transaction sequencer directly upstream of the SPI host core wrapper. Takes one flash read request (24-bit address, byte count) and emits the command segments and TX word that the core needs for a standard (0x03) or fast (0x0B) SPI flash read. Collects the returned RX words and forwards them through a registered output stage with per-word byte enables and a last flag. Single SPI mode only, chip select 0.

## Interface
Parameters:
- none. All constants live in the package.

Ports:
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  reset; synchronous, active-high
- cfg_clkdiv_i  in  16  SCK divider, sampled at request accept
- cfg_cpol_i, cfg_cpha_i  in  1 each  SPI mode, sampled at request accept
- cfg_fast_i  in  1  0: opcode 0x03; 1: opcode 0x0B plus 8 dummy cycles; sampled at request accept
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_addr_i  in  24  flash byte address
- req_len_i  in  9  byte count minus one (0..511)
- command_csid, command_clkdiv, command_csnidle, command_csnlead, command_csntrail, command_full_cyc, command_cpha, command_cpol, command_speed, command_cmd_wr_en, command_cmd_rd_en, command_len, command_csaat  out  1/16/4/4/4/1/1/1/2/1/1/9/1  command fields to the core wrapper
- command_valid_o / command_ready_i  out/in  1  command handshake
- tx_data_o  out  32  TX word to the core
- tx_be_o  out  4  TX byte enables to the core
- tx_valid_o / tx_ready_i  out/in  1  TX handshake
- rx_data_i  in  32  RX word from the core
- rx_valid_i / rx_ready_o  in/out  1  RX handshake
- rd_data_o  out  32  read data word
- rd_be_o  out  4  read data byte enables
- rd_last_o  out  1  marks the final word of the request
- rd_valid_o / rd_ready_i  out/in  1  read data handshake
- busy_o  out  1  high in every state except IDLE

## Operation
- State machine: IDLE, TXW, CMD1, DUMMY, CMD2, RX.
- IDLE
  - req_ready_o=1.
  - On req_valid_i, latch the address, length and cfg inputs; set word counter = req_len_i[8:2]+1; go to TXW.
- TXW
  - tx_valid_o=1, tx_data_o={addr[7:0], addr[15:8], addr[23:16], opcode}, tx_be_o=4'hF.
  - Opcode sits in byte 0 because byte 0 is sent first.
  - On tx_ready_i, go to CMD1.
- CMD1
  - Segment: len=3, cmd_wr_en=1, cmd_rd_en=0, csaat=1.
  - On handshake, go to DUMMY if fast, otherwise CMD2.
- DUMMY
  - Segment: len=7, cmd_wr_en=0, cmd_rd_en=0, csaat=1 (8 dummy cycles).
  - On handshake, go to CMD2.
- CMD2
  - Segment: len=latched req_len, cmd_wr_en=0, cmd_rd_en=1, csaat=0.
  - On handshake, go to RX.
- Fixed command fields in every state: csid=0, csnidle=csnlead=csntrail=1, full_cyc=0, speed=0 (standard).
  - clkdiv, cpol and cpha come from the latched cfg values.
  - All command fields are held stable while command_valid_o is high.
- RX
  - rx_ready_o = !rd_valid_o || rd_ready_i.
  - Each RX handshake loads the output register and decrements the word counter.
  - The word that brings the counter to 0 sets rd_last_o=1.
  - rd_be_o=4'hF except on the last word, where it is (4'b0001<<(req_len[1:0]+1))-1.
  - Example: 4'b0011 for 2 remaining bytes.
- RX exit
  - Once the last word is accepted from the core, go to IDLE.
  - The output register drains independently of the state.
  - A new request is accepted only when rd_valid_o=0 or the last word is being taken in the same cycle.
- Width rules
  - The word counter is 8 bits (max 128).
  - Counter arithmetic is unsigned with no wrap; it is only decremented while nonzero.
- Reset mid-operation
  - State goes to IDLE and the output register is cleared.
  - No partial transaction resumes.
  - The system must reset the core concurrently (its sw_rst_i).

## Timing
- Reset values: command_valid_o=0, tx_valid_o=0, rx_ready_o=0, rd_valid_o=0, rd_last_o=0, rd_be_o=0, rd_data_o=0, busy_o=0.
  - req_ready_o=1 from the first cycle after reset.
  - Command fields reset to their IDLE defaults.
- Request accept to tx_valid_o: 1 cycle.
- Each handshake advances the state in the next cycle; there are no bubble cycles beyond that.
- rx handshake to rd_valid_o: 1 cycle (registered).
- Full throughput: one word per cycle when rd_ready_i is held high.
- The valid outputs never depend combinationally on the corresponding ready inputs.
- rx_ready_o depends combinationally on rd_ready_i.

## Structure
- Package spi_flash_seq_pkg holds:
  - state_t enum;
  - OP_READ=8'h03, OP_FAST_READ=8'h0B;
  - DUMMY_LEN=9'd7, CMD_LEN=9'd3;
  - fixed CSN timing constants.
- No sub-module: the one-entry output register is inline.
- Instantiated alongside spi_host_core_wrap; its ports connect by name.

## Test plan
- Standard read, addr 0x123456, len 3:
  - TX word 0x56341203, be F.
  - CMD1 len 3 csaat 1, then CMD2 len 3 rd_en csaat 0.
  - One rd word with be F and last=1.
- Fast read, len 5:
  - TX word 0x5634120B.
  - DUMMY segment with len 7 and neither enable set.
  - Two rd words; the second has be 4'b0011 and last=1.
- command_ready_i held low 5 cycles in CMD1:
  - command_valid_o stays 1 and all fields stay constant.
  - Handshake happens exactly once.
- rd_ready_i low for 10 cycles mid-RX, len 31:
  - rx_ready_o drops while the register is full.
  - Exactly 8 words out, in order, with no duplicates.
- Len 511: 128 words out; rd_last_o only on the 128th.
- rst_i asserted in RX:
  - In the next cycle all valids are 0, busy_o=0 and req_ready_o=1.
  - A following request runs normally.

Source files
------------

// File: rtl/spi_flash_seq_pkg.sv
// spi_flash_seq_pkg: shared states, opcodes and segment constants for the flash read sequencer
package spi_flash_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TXW, S_CMD1, S_DUMMY, S_CMD2, S_RX} state_t;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [8:0] DUMMY_LEN = 9'd7;
  localparam logic [8:0] CMD_LEN = 9'd3;
  localparam logic [3:0] CSN_IDLE = 4'd1;
  localparam logic [3:0] CSN_LEAD = 4'd1;
  localparam logic [3:0] CSN_TRAIL = 4'd1;
  function automatic logic [3:0] be_mask(input logic [1:0] l);
    logic [4:0] m;
    m = 5'd1 << (3'(l) + 3'd1);
    return 4'(m - 5'd1);
  endfunction
endpackage

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: sequences standard/fast SPI flash reads and forwards RX words with byte enables
module spi_flash_rd_seq
  import spi_flash_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cfg_clkdiv_i,
  input  logic        cfg_cpol_i,
  input  logic        cfg_cpha_i,
  input  logic        cfg_fast_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  input  logic [8:0]  req_len_i,
  output logic        command_csid,
  output logic [15:0] command_clkdiv,
  output logic [3:0]  command_csnidle,
  output logic [3:0]  command_csnlead,
  output logic [3:0]  command_csntrail,
  output logic        command_full_cyc,
  output logic        command_cpha,
  output logic        command_cpol,
  output logic [1:0]  command_speed,
  output logic        command_cmd_wr_en,
  output logic        command_cmd_rd_en,
  output logic [8:0]  command_len,
  output logic        command_csaat,
  output logic        command_valid_o,
  input  logic        command_ready_i,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_be_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] rd_data_o,
  output logic [3:0]  rd_be_o,
  output logic        rd_last_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic        busy_o
);
  state_t state_q, state_d;
  logic [8:0] len_q, len_d, cmd_len_q, cmd_len_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic [31:0] tx_data_q, tx_data_d, rd_data_q, rd_data_d;
  logic [3:0] tx_be_q, tx_be_d, rd_be_q, rd_be_d;
  logic fast_q, fast_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic tx_valid_q, tx_valid_d, cmd_valid_q, cmd_valid_d;
  logic cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d, csaat_q, csaat_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic req_fire, tx_fire, cmd_fire, rx_fire, last_word;
  assign req_ready_o = (state_q == S_IDLE) && (!rd_valid_q || rd_ready_i);
  assign rx_ready_o = (state_q == S_RX) && (!rd_valid_q || rd_ready_i);
  assign busy_o = state_q != S_IDLE;
  assign command_csid = 1'b0;
  assign command_csnidle = CSN_IDLE;
  assign command_csnlead = CSN_LEAD;
  assign command_csntrail = CSN_TRAIL;
  assign command_full_cyc = 1'b0;
  assign command_speed = 2'd0;
  assign command_clkdiv = clkdiv_q;
  assign command_cpol = cpol_q;
  assign command_cpha = cpha_q;
  assign command_len = cmd_len_q;
  assign command_cmd_wr_en = cmd_wr_q;
  assign command_cmd_rd_en = cmd_rd_q;
  assign command_csaat = csaat_q;
  assign command_valid_o = cmd_valid_q;
  assign tx_data_o = tx_data_q;
  assign tx_be_o = tx_be_q;
  assign tx_valid_o = tx_valid_q;
  assign rd_data_o = rd_data_q;
  assign rd_be_o = rd_be_q;
  assign rd_last_o = rd_last_q;
  assign rd_valid_o = rd_valid_q;
  always_comb begin
    req_fire = req_valid_i && req_ready_o;
    tx_fire = tx_valid_q && tx_ready_i;
    cmd_fire = cmd_valid_q && command_ready_i;
    rx_fire = rx_valid_i && rx_ready_o;
    last_word = wcnt_q == 8'd1;
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire) state_d = S_TXW;
      S_TXW:   if (tx_fire) state_d = S_CMD1;
      S_CMD1:  if (cmd_fire) state_d = fast_q ? S_DUMMY : S_CMD2;
      S_DUMMY: if (cmd_fire) state_d = S_CMD2;
      S_CMD2:  if (cmd_fire) state_d = S_RX;
      S_RX:    if (rx_fire && last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    len_d = req_fire ? req_len_i : len_q;
    fast_d = req_fire ? cfg_fast_i : fast_q;
    clkdiv_d = req_fire ? cfg_clkdiv_i : clkdiv_q;
    cpol_d = req_fire ? cfg_cpol_i : cpol_q;
    cpha_d = req_fire ? cfg_cpha_i : cpha_q;
    wcnt_d = req_fire ? 8'(req_len_i[8:2]) + 8'd1 :
             (rx_fire && wcnt_q != 8'd0) ? wcnt_q - 8'd1 : wcnt_q;
    tx_data_d = req_fire ? {req_addr_i[7:0], req_addr_i[15:8], req_addr_i[23:16],
                            cfg_fast_i ? OP_FAST_READ : OP_READ} : tx_data_q;
    tx_valid_d = state_d == S_TXW;
    tx_be_d = tx_valid_d ? 4'hF : 4'h0;
    cmd_valid_d = state_d inside {S_CMD1, S_DUMMY, S_CMD2};
    cmd_len_d = state_d == S_CMD1 ? CMD_LEN : state_d == S_DUMMY ? DUMMY_LEN :
                state_d == S_CMD2 ? len_d : 9'd0;
    cmd_wr_d = state_d == S_CMD1;
    cmd_rd_d = state_d == S_CMD2;
    csaat_d = state_d inside {S_CMD1, S_DUMMY};
    rd_valid_d = rx_fire || (rd_valid_q && !rd_ready_i);
    rd_data_d = rx_fire ? rx_data_i : rd_data_q;
    rd_last_d = rx_fire ? last_word : rd_last_q;
    rd_be_d = rx_fire ? (last_word ? be_mask(len_q[1:0]) : 4'hF) : rd_be_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q <= '0;
      fast_q <= 1'b0;
      clkdiv_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      wcnt_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      tx_be_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_len_q <= '0;
      cmd_wr_q <= 1'b0;
      cmd_rd_q <= 1'b0;
      csaat_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
      rd_be_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      fast_q <= fast_d;
      clkdiv_q <= clkdiv_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      wcnt_q <= wcnt_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_be_q <= tx_be_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_len_q <= cmd_len_d;
      cmd_wr_q <= cmd_wr_d;
      cmd_rd_q <= cmd_rd_d;
      csaat_q <= csaat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      rd_last_q <= rd_last_d;
      rd_be_q <= rd_be_d;
    end
  end
endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: randomized self-checking bench against a transaction-level read model
module tb_spi_flash_rd_seq;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [15:0] cfg_clkdiv_i = '0;
  logic cfg_cpol_i = 1'b0, cfg_cpha_i = 1'b0, cfg_fast_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [23:0] req_addr_i = '0;
  logic [8:0] req_len_i = '0;
  logic command_csid, command_full_cyc, command_cpha, command_cpol;
  logic [15:0] command_clkdiv;
  logic [3:0] command_csnidle, command_csnlead, command_csntrail;
  logic [1:0] command_speed;
  logic command_cmd_wr_en, command_cmd_rd_en, command_csaat, command_valid_o;
  logic [8:0] command_len;
  logic command_ready_i = 1'b0;
  logic [31:0] tx_data_o;
  logic [3:0] tx_be_o;
  logic tx_valid_o;
  logic tx_ready_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_ready_o;
  logic [31:0] rd_data_o;
  logic [3:0] rd_be_o;
  logic rd_last_o, rd_valid_o, busy_o;
  logic rd_ready_i = 1'b0;
  int n_checks = 0, n_fail = 0;
  int cmd_changed, stall_bad, stall_low_seen;

  always #5 clk_i = ~clk_i;

  spi_flash_rd_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_clkdiv_i(cfg_clkdiv_i), .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i), .cfg_fast_i(cfg_fast_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .command_csid(command_csid), .command_clkdiv(command_clkdiv), .command_csnidle(command_csnidle),
    .command_csnlead(command_csnlead), .command_csntrail(command_csntrail), .command_full_cyc(command_full_cyc),
    .command_cpha(command_cpha), .command_cpol(command_cpol), .command_speed(command_speed),
    .command_cmd_wr_en(command_cmd_wr_en), .command_cmd_rd_en(command_cmd_rd_en), .command_len(command_len),
    .command_csaat(command_csaat), .command_valid_o(command_valid_o), .command_ready_i(command_ready_i),
    .tx_data_o(tx_data_o), .tx_be_o(tx_be_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rd_data_o(rd_data_o), .rd_be_o(rd_be_o), .rd_last_o(rd_last_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .busy_o(busy_o)
  );

  task automatic run_txn(input string tag, input logic [23:0] addr, input logic [8:0] len, input logic fast,
                         input int cmd_hold, input int stall_at, input int abort_at, input bit rnd);
    int nwords, nseg, rx_i, rd_n, segs, txs, cyc, w, hold, stall_left, first_cyc, last_cyc, rem, exp_n;
    int e_len[3];
    bit e_wr[3], e_rd[3], e_cs[3];
    logic [31:0] words[$];
    logic [31:0] exp_tx;
    logic [3:0] exp_be;
    logic [15:0] div;
    logic pol, pha;
    logic [46:0] snap;
    bit rd_seg;
    nwords = (int'(len) + 4) / 4;
    nseg = fast ? 3 : 2;
    e_len[0] = 3; e_wr[0] = 1; e_rd[0] = 0; e_cs[0] = 1;
    e_len[1] = 7; e_wr[1] = 0; e_rd[1] = 0; e_cs[1] = 1;
    e_len[nseg-1] = int'(len); e_wr[nseg-1] = 0; e_rd[nseg-1] = 1; e_cs[nseg-1] = 0;
    exp_tx = 32'(fast ? 8'h0B : 8'h03) | (32'(addr[23:16]) << 8) | (32'(addr[15:8]) << 16) | (32'(addr[7:0]) << 24);
    for (int i = 0; i < nwords; i++) words.push_back($urandom);
    div = 16'($urandom); pol = 1'($urandom); pha = 1'($urandom);
    rx_i = 0; rd_n = 0; segs = 0; txs = 0; cyc = 0; hold = 0; stall_left = 0;
    first_cyc = 0; last_cyc = 0; rd_seg = 0; snap = '0;
    cmd_changed = 0; stall_bad = 0; stall_low_seen = 0;
    @(negedge clk_i);
    cfg_clkdiv_i = div; cfg_cpol_i = pol; cfg_cpha_i = pha; cfg_fast_i = fast;
    req_addr_i = addr; req_len_i = len; req_valid_i = 1'b1;
    #1;
    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      #1;
      w++;
    end
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_accept: req_ready_o=%b required 1", tag, req_ready_o);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cfg_clkdiv_i = 16'($urandom); cfg_cpol_i = ~pol; cfg_cpha_i = ~pha; cfg_fast_i = ~fast;
    req_addr_i = 24'($urandom); req_len_i = 9'($urandom);
    n_checks++;
    if (tx_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tx_latency: tx_valid_o=%b required 1", tag, tx_valid_o);
    end
    while (cyc < 4000) begin
      cyc++;
      tx_ready_i = rnd ? 1'($urandom) : 1'b1;
      if ((command_valid_o || hold > 0) && hold < cmd_hold) begin
        command_ready_i = 1'b0;
        if (hold == 0)
          snap = {command_valid_o, command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat, command_clkdiv,
                  command_cpol, command_cpha, command_csid, command_csnidle, command_csnlead, command_csntrail,
                  command_full_cyc, command_speed};
        else if ({command_valid_o, command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat, command_clkdiv,
                  command_cpol, command_cpha, command_csid, command_csnidle, command_csnlead, command_csntrail,
                  command_full_cyc, command_speed} !== snap)
          cmd_changed++;
        hold++;
      end else begin
        command_ready_i = rnd ? 1'($urandom) : 1'b1;
      end
      rx_valid_i = rd_seg && rx_i < nwords && (rnd ? 1'($urandom) : 1'b1);
      rx_data_i = rx_valid_i ? words[rx_i] : $urandom;
      rd_ready_i = stall_left > 0 ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      #1;
      if (stall_left > 0 && rd_valid_o) begin
        if (rx_ready_o) stall_bad++;
        else stall_low_seen++;
      end
      if (tx_valid_o && tx_ready_i) begin
        txs++;
        n_checks++;
        if ({tx_data_o, tx_be_o} !== {exp_tx, 4'hF}) begin
          n_fail++;
          $display("FAIL %s tx_word: got %h be %h required %h be f", tag, tx_data_o, tx_be_o, exp_tx);
        end
      end
      if (command_valid_o && command_ready_i) begin
        if (segs < nseg) begin
          n_checks++;
          if ({command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat} !==
              {9'(e_len[segs]), e_wr[segs], e_rd[segs], e_cs[segs]}) begin
            n_fail++;
            $display("FAIL %s seg%0d: got len %0d wr %b rd %b csaat %b required len %0d wr %b rd %b csaat %b", tag, segs,
                     command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat,
                     e_len[segs], e_wr[segs], e_rd[segs], e_cs[segs]);
          end
          n_checks++;
          if ({command_csid, command_csnidle, command_csnlead, command_csntrail, command_full_cyc, command_speed,
               command_clkdiv, command_cpol, command_cpha} !== {1'b0, 4'd1, 4'd1, 4'd1, 1'b0, 2'd0, div, pol, pha}) begin
            n_fail++;
            $display("FAIL %s seg%0d_fixed: got csid %b idle %h lead %h trail %h fc %b spd %h div %h pol %b pha %b required div %h pol %b pha %b",
                     tag, segs, command_csid, command_csnidle, command_csnlead, command_csntrail, command_full_cyc,
                     command_speed, command_clkdiv, command_cpol, command_cpha, div, pol, pha);
          end
          rd_seg = rd_seg | e_rd[segs];
        end
        segs++;
      end
      if (rx_valid_i && rx_ready_o) rx_i++;
      if (stall_left > 0) stall_left--;
      if (rd_valid_o && rd_ready_i) begin
        if (rd_n < nwords) begin
          rem = int'(len) + 1 - 4 * rd_n;
          exp_be = rem >= 4 ? 4'hF : 4'((1 << rem) - 1);
          n_checks++;
          if ({rd_data_o, rd_be_o, rd_last_o} !== {words[rd_n], exp_be, rd_n == nwords - 1}) begin
            n_fail++;
            $display("FAIL %s rd_word%0d: got %h be %h last %b required %h be %h last %b", tag, rd_n,
                     rd_data_o, rd_be_o, rd_last_o, words[rd_n], exp_be, rd_n == nwords - 1);
          end
        end
        if (rd_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        rd_n++;
        if (rd_n == stall_at) stall_left = 10;
      end
      if ((abort_at > 0 && rd_n == abort_at) || rd_n == nwords) break;
      @(negedge clk_i);
    end
    exp_n = abort_at > 0 ? abort_at : nwords;
    n_checks++;
    if (rd_n !== exp_n) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d required %0d (cycles %0d)", tag, rd_n, exp_n, cyc);
    end
    n_checks++;
    if (txs !== 1 || segs !== nseg) begin
      n_fail++;
      $display("FAIL %s handshake_count: got tx %0d seg %0d required tx 1 seg %0d", tag, txs, segs, nseg);
    end
    if (abort_at == 0) begin
      tx_ready_i = 1'b0; command_ready_i = 1'b0; rx_valid_i = 1'b0;
      @(negedge clk_i);
      rd_ready_i = 1'b0;
      #1;
      n_checks++;
      if ({busy_o, rd_valid_o, req_ready_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL %s end_idle: got busy %b rd_valid %b req_ready %b required 0 0 1", tag, busy_o, rd_valid_o, req_ready_o);
      end
      if (!rnd && cmd_hold == 0 && stall_at == 0) begin
        n_checks++;
        if (last_cyc - first_cyc !== nwords - 1) begin
          n_fail++;
          $display("FAIL %s throughput: got span %0d required %0d", tag, last_cyc - first_cyc, nwords - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({command_valid_o, tx_valid_o, rx_ready_o, rd_valid_o, rd_last_o, rd_be_o, rd_data_o, busy_o,
         command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_values: cv %b tv %b rxr %b rdv %b last %b be %h data %h busy %b len %0d wr %b rd %b csaat %b required all 0",
               command_valid_o, tx_valid_o, rx_ready_o, rd_valid_o, rd_last_o, rd_be_o, rd_data_o, busy_o,
               command_len, command_cmd_wr_en, command_cmd_rd_en, command_csaat);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b required 1", req_ready_o);
    end
  endtask

  task automatic test_std_read();
    run_txn("std_read", 24'h123456, 9'd3, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_fast_read();
    run_txn("fast_read", 24'h123456, 9'd5, 1'b1, 0, 0, 0, 1'b0);
    run_txn("fast_read_rand", 24'($urandom), 9'd5, 1'b1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_cmd_stall();
    run_txn("cmd_stall", 24'($urandom), 9'd9, 1'b0, 5, 0, 0, 1'b0);
    n_checks++;
    if (cmd_changed !== 0) begin
      n_fail++;
      $display("FAIL cmd_stall_stable: got %0d changed cycles required 0", cmd_changed);
    end
  endtask

  task automatic test_rd_stall();
    run_txn("rd_stall", 24'($urandom), 9'd31, 1'b1, 0, 3, 0, 1'b0);
    n_checks++;
    if (stall_bad !== 0 || stall_low_seen == 0) begin
      n_fail++;
      $display("FAIL rd_stall_rx_ready: got %0d ready-while-full, %0d held-off cycles required 0 and >0", stall_bad, stall_low_seen);
    end
  endtask

  task automatic test_len_max();
    run_txn("len_max", 24'($urandom), 9'd511, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_boundary_lens();
    for (int l = 0; l < 8; l++) run_txn("short_len", 24'($urandom), 9'(l), 1'(l), 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++)
      run_txn("random", 24'($urandom), 9'($urandom_range(0, t < 16 ? 63 : 511)), 1'($urandom), 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_rx();
    run_txn("mid_rx", 24'($urandom), 9'd31, 1'b0, 0, 0, 2, 1'b0);
    rst_i = 1'b1;
    tx_ready_i = 1'b0; command_ready_i = 1'b0; rx_valid_i = 1'b0; rd_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid_o, command_valid_o, rd_valid_o, rx_ready_o, rd_last_o, busy_o, req_ready_o} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL mid_rx_reset: tv %b cv %b rdv %b rxr %b last %b busy %b req_ready %b required 0 0 0 0 0 0 1",
               tx_valid_o, command_valid_o, rd_valid_o, rx_ready_o, rd_last_o, busy_o, req_ready_o);
    end
    run_txn("after_reset", 24'($urandom), 9'd13, 1'b1, 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_std_read();
    test_fast_read();
    test_cmd_stall();
    test_rd_stall();
    test_len_max();
    test_boundary_lens();
    test_random();
    test_reset_mid_rx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
